sll_seq: RTL

- Iterative left-shift sequencer. Performs a variable-amount logical left shift by stepping the catalog's fixed 1-bit sll stage once per clock.
- Accepts an operand and a shift amount over a valid/ready handshake. Counts down the amount, one bit per cycle. Presents the result over a second valid/ready handshake.
- Serves as the area-cheap alternative to a barrel shifter in the catalog datapath.

---
 rtl/sll_seq_pkg.sv | 20 ++
 rtl/sll_seq_sll.sv | 15 +
 rtl/sll_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sll_seq_pkg.sv
// Shared types and helpers for the sll_seq iterative left-shift sequencer.
package sll_seq_pkg;

    // Sequencer states; the encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Width of the shift-amount port for an n-bit operand (legal amounts 0..n-1).
    function automatic int amt_width(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/sll_seq_sll.sv
// Catalog fixed-amount logical left-shift stage (combinational).
// With en high the operand moves left by 'shift' positions and zeros fill the
// low bits; with en low the operand passes through unchanged.
module sll_seq_sll #(
    parameter int n     = 8,
    parameter int shift = 1
) (
    input  logic         en,
    input  logic [n-1:0] a,
    output logic [n-1:0] y
);

    assign y = en ? (a << shift) : a;

endmodule

// File: rtl/sll_seq.sv
// Iterative left-shift sequencer: accepts an operand and amount over a
// valid/ready handshake, applies one 1-bit shift per clock, and presents the
// result over a second valid/ready handshake.
// Optional feature: define SLL_SEQ_OVF_EN to add the sticky 'ovf' output that
// flags any 1 bit shifted out of the MSB during the operation.
module sll_seq
    import sll_seq_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = amt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [N-1:0]  din,
    input  logic [AW-1:0] amt,
    output logic          busy,
    output logic          done_valid,
    input  logic          done_ready,
`ifdef SLL_SEQ_OVF_EN
    output logic          ovf,
`endif
    output logic [N-1:0]  dout
);

    localparam logic [AW-1:0] CNT_ONE = AW'(1);

    state_e        state_q;
    state_e        state_d;
    logic [N-1:0]  data_q;
    logic [N-1:0]  data_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    logic [AW-1:0] amt_c;
    logic [N-1:0]  shift_y;

    // Amounts beyond N-1 can only be encoded when N is not a power of two;
    // they saturate at N-1 so the counter never exceeds the operand width.
    if ((1 << AW) > N) begin : g_clamp
        // Saturate out-of-range shift amounts to N-1.
        always_comb begin
            if (int'(amt) > (N - 1)) begin
                amt_c = AW'(N - 1);
            end else begin
                amt_c = amt;
            end
        end
    end else begin : g_noclamp
        assign amt_c = amt;
    end

    // Single 1-bit shift step that feeds the data register while shifting.
    sll_seq_sll #(
        .n     (N),
        .shift (1)
    ) u_step (
        .en (1'b1),
        .a  (data_q),
        .y  (shift_y)
    );

    // Next-state logic: load on start handshake, count down while shifting,
    // release the result on the done handshake.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    data_d = din;
                    cnt_d  = amt_c;
                    if (amt_c != {AW{1'b0}}) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d = shift_y;
                cnt_d  = cnt_q - CNT_ONE;
                // Exit at one so the counter never wraps below zero.
                if (cnt_q <= CNT_ONE) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                // No new start is taken in this cycle; start_ready rises next cycle.
                if (done_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = {N{1'b0}};
                cnt_d   = {AW{1'b0}};
            end
        endcase
    end

    // State, data and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= {N{1'b0}};
            cnt_q   <= {AW{1'b0}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SLL_SEQ_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Sticky overflow: cleared on start handshake, set when a 1 leaves the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == IDLE) && start_valid) begin
            ovf_d = 1'b0;
        end else if (state_q == SHIFT) begin
            ovf_d = ovf_q | data_q[N-1];
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // Handshake outputs decode directly from the registered state.
    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == SHIFT) || (state_q == DONE);
    assign done_valid  = (state_q == DONE);
    assign dout        = data_q;

endmodule
